// File: rtl/imem_boot_loader_if.sv
// Byte-stream / IMEM-write / status bundle for the instruction memory boot loader.
// The loader sits on the slave side; the host/bench drives the master side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;
  logic [15:0]       words_loaded;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata,
           busy, done, error, cpu_hold, words_loaded
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata,
           busy, done, error, cpu_hold, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: takes LEN (16b, LSB first) then LEN little-endian words from a byte stream,
// writes them to IMEM at consecutive word addresses and holds the CPU until loading is done.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset, waiting for start, CPU held
// LEN_LO  | waiting for low byte of program length
// LEN_HI  | waiting for high byte of program length, then range check
// DATA    | collecting the 4 bytes of the current word
// WRITE   | one-cycle IMEM write of the assembled word, stream stalled
// DONE    | program loaded, CPU released
// ERR     | length rejected, CPU held
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1001
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  imem_boot_loader_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       len, len_nx;
  logic [1:0]        byte_cnt, byte_cnt_nx;
  logic [23:0]       shift, shift_nx;
  logic [15:0]       words_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic [15:0]       len_full;
  logic              xfer;

  assign xfer     = bus.rx_valid & bus.rx_ready;
  assign len_full = {bus.rx_data, len[7:0]};

  always_comb begin
    state_nx    = state;
    len_nx      = len;
    byte_cnt_nx = byte_cnt;
    shift_nx    = shift;
    words_nx    = bus.words_loaded;
    addr_nx     = bus.mem_addr;
    wdata_nx    = bus.mem_wdata;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_nx    = S_LEN_LO;
          words_nx    = '0;
          byte_cnt_nx = '0;
          len_nx      = '0;
        end
      end

      S_LEN_LO: begin
        if (xfer) begin
          len_nx   = {8'h00, bus.rx_data};
          state_nx = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (xfer) begin
          len_nx = len_full;
          if (len_full == 16'h0000) begin
            state_nx = S_DONE;
          end else if (len_full > MAX_LEN) begin
            state_nx = S_ERR;
          end else begin
            state_nx = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          byte_cnt_nx = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            // Last byte goes straight to the write data; the shifter holds bytes 0..2.
            wdata_nx = {bus.rx_data, shift};
            addr_nx  = bus.words_loaded[ADDR_W-1:0];
            state_nx = S_WRITE;
          end else begin
            shift_nx = {bus.rx_data, shift[23:8]};
          end
        end
      end

      S_WRITE: begin
        if (bus.words_loaded < len) begin
          words_nx = bus.words_loaded + 16'd1;
        end
        if ((bus.words_loaded + 16'd1) >= len) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DATA;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet in step with it.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state            <= S_IDLE;
      len              <= '0;
      byte_cnt         <= '0;
      shift            <= '0;
      bus.words_loaded <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.rx_ready     <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.cpu_hold     <= 1'b1;
    end else begin
      state            <= state_nx;
      len              <= len_nx;
      byte_cnt         <= byte_cnt_nx;
      shift            <= shift_nx;
      bus.words_loaded <= words_nx;
      bus.mem_addr     <= addr_nx;
      bus.mem_wdata    <= wdata_nx;
      bus.rx_ready     <= (state_nx == S_LEN_LO) || (state_nx == S_LEN_HI) ||
                          (state_nx == S_DATA);
      bus.mem_we       <= (state_nx == S_WRITE);
      bus.busy         <= (state_nx == S_LEN_LO) || (state_nx == S_LEN_HI) ||
                          (state_nx == S_DATA)   || (state_nx == S_WRITE);
      bus.done         <= (state_nx == S_DONE);
      bus.error        <= (state_nx == S_ERR);
      bus.cpu_hold     <= (state_nx != S_DONE);
    end
  end

endmodule
